// File: rtl/truth_table_capture_if.sv
// truth_table_capture_if: controller/gate <-> characterizer bundle.
// start and sample flow in; drive and the captured results flow out.
interface truth_table_capture_if #(
    parameter int N_IN = 3
);
    logic                 start;
    logic                 sample;
    logic [N_IN-1:0]      drive;
    logic                 busy;
    logic                 valid;
    logic [(1<<N_IN)-1:0] table_out;
    logic                 unstable;

    modport master (
        output start,
        output sample,
        input  drive,
        input  busy,
        input  valid,
        input  table_out,
        input  unstable
    );

    modport slave (
        input  start,
        input  sample,
        output drive,
        output busy,
        output valid,
        output table_out,
        output unstable
    );
endinterface

// File: rtl/truth_table_capture.sv
// truth_table_capture: sweeps all input vectors of an N-input gate
// and assembles its truth-table code, vector 0 in the MSB.
module truth_table_capture #(
    parameter int N_IN   = 3,
    parameter int SETTLE = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    truth_table_capture_if.slave bus
);
    localparam int W  = 1 << N_IN;
    localparam int CW = $clog2(SETTLE + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
    localparam logic [N_IN:0] VEC_LAST = (N_IN + 1)'(W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE_W,
        SAMP_A,
        SAMP_B
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [N_IN:0]   r_vec;
    logic [CW-1:0]   r_cnt;
    logic            r_sa;
    logic [W-1:0]    r_shadow;
    logic            r_sh_unst;
    logic [N_IN-1:0] r_drive;
    logic            r_busy;
    logic            r_valid;
    logic [W-1:0]    r_table;
    logic            r_unstable;

    logic [N_IN-1:0] w_idx;
    logic [W-1:0]    w_shadow;
    logic            w_unst;
    logic            w_last;

    // State register; reset abandons any sweep in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: settle, two samples per vector, loop until last vector.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:     if (bus.start) w_next = SETTLE_W;
            SETTLE_W: if (r_cnt == CNT_LAST) w_next = SAMP_A;
            SAMP_A:   w_next = SAMP_B;
            SAMP_B:   w_next = w_last ? IDLE : SETTLE_W;
            default:  w_next = IDLE;
        endcase
    end

    // Shadow with the current B sample merged in; index W-1-vec is ~vec.
    always_comb begin
        w_idx           = ~r_vec[N_IN-1:0];
        w_shadow        = r_shadow;
        w_shadow[w_idx] = bus.sample;
        w_unst          = r_sh_unst | (bus.sample != r_sa);
        w_last          = (r_vec == VEC_LAST);
    end

    // Sweep datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec      <= '0;
            r_cnt      <= '0;
            r_sa       <= 1'b0;
            r_shadow   <= '0;
            r_sh_unst  <= 1'b0;
            r_drive    <= '0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_table    <= '0;
            r_unstable <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_vec     <= '0;
                        r_cnt     <= '0;
                        r_shadow  <= '0;
                        r_sh_unst <= 1'b0;
                        r_busy    <= 1'b1;
                        r_drive   <= '0;
                    end
                end
                SETTLE_W: begin
                    r_cnt <= r_cnt + 1'b1;
                end
                SAMP_A: begin
                    r_sa <= bus.sample;
                end
                SAMP_B: begin
                    r_shadow  <= w_shadow;
                    r_sh_unst <= w_unst;
                    if (w_last) begin
                        r_table    <= w_shadow;
                        r_unstable <= w_unst;
                        r_valid    <= 1'b1;
                        r_busy     <= 1'b0;
                        r_drive    <= '0;
                    end else begin
                        r_vec   <= r_vec + 1'b1;
                        r_drive <= r_vec[N_IN-1:0] + 1'b1;
                        r_cnt   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.drive     = r_drive;
    assign bus.busy      = r_busy;
    assign bus.valid     = r_valid;
    assign bus.table_out = r_table;
    assign bus.unstable  = r_unstable;
endmodule

// File: tb/tb_truth_table_capture.sv
// tb_truth_table_capture: scoreboard bench for two characterizers
// (3-input/SETTLE 4 and 2-input/SETTLE 1) driving behavioural gates.
module tb_truth_table_capture;
    localparam int SET3 = 4;
    localparam int SET2 = 1;
    localparam int P3   = 8 * (SET3 + 2);
    localparam int P2   = 4 * (SET2 + 2);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    truth_table_capture_if #(.N_IN(3)) b3 ();
    truth_table_capture_if #(.N_IN(2)) b2 ();

    truth_table_capture #(.N_IN(3), .SETTLE(SET3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b3)
    );

    truth_table_capture #(.N_IN(2), .SETTLE(SET2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b2)
    );

    // Gates under test: output looked up by input vector.
    bit lut3 [8];
    bit lut2 [4];
    bit glitch3 = 1'b0;

    assign b3.sample = lut3[b3.drive] ^ glitch3;
    assign b2.sample = lut2[b2.drive];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)",
                     nm, got, exp, $time);
        end
    endtask

    typedef struct {
        int tbl;
        int unst;
        int t_done;
    } exp_t;

    exp_t q3[$];
    exp_t q2[$];
    int   e0_3  = -1000;
    int   e0_2  = -1000;
    int   nval3 = 0;
    int   nval2 = 0;

    // Truth-table code: vector v contributes bit (2^N-1-v).
    function automatic int model3();
        int t = 0;
        for (int v = 0; v < 8; v++)
            if (lut3[v]) t |= 1 << (7 - v);
        return t;
    endfunction

    function automatic int model2();
        int t = 0;
        for (int v = 0; v < 4; v++)
            if (lut2[v]) t |= 1 << (3 - v);
        return t;
    endfunction

    task automatic set_e3();
        for (int v = 0; v < 8; v++)
            lut3[v] = (v == 0 || v == 1 || v == 2 || v == 6 || v == 7);
    endtask

    task automatic push3(input int unst);
        exp_t e;
        e.tbl    = model3();
        e.unst   = unst;
        e.t_done = e0_3 + P3;
        q3.push_back(e);
    endtask

    task automatic push2();
        exp_t e;
        e.tbl    = model2();
        e.unst   = 0;
        e.t_done = e0_2 + P2;
        q2.push_back(e);
    endtask

    task automatic go3(input bit acc, input int unst);
        @(negedge clk);
        b3.start = 1'b1;
        @(posedge clk);
        #1;
        b3.start = 1'b0;
        if (acc) begin
            e0_3 = cyc;
            push3(unst);
        end
    endtask

    task automatic go2();
        @(negedge clk);
        b2.start = 1'b1;
        @(posedge clk);
        #1;
        b2.start = 1'b0;
        e0_2 = cyc;
        push2();
    endtask

    task automatic wait_idle3();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (q3.size() == 0) break;
        end
        chk("timeout3", q3.size(), 0);
    endtask

    task automatic wait_idle2();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (q2.size() == 0) break;
        end
        chk("timeout2", q2.size(), 0);
    endtask

    // Monitor for the 3-input instance.
    always @(negedge clk) begin
        int   rel;
        exp_t e;
        if (rst_n) begin
            rel = cyc - e0_3;
            if (rel >= 0 && rel < P3) begin
                chk("busy3", b3.busy, 1);
                chk("drive3", b3.drive, rel / (SET3 + 2));
            end
            if (b3.valid) begin
                nval3++;
                chk("busy_fall3", b3.busy, 0);
                if (q3.size() == 0) begin
                    chk("unexpected_valid3", 1, 0);
                end else begin
                    e = q3.pop_front();
                    chk("table3", b3.table_out, e.tbl);
                    chk("unstable3", b3.unstable, e.unst);
                    chk("done_time3", cyc, e.t_done);
                end
            end
        end
    end

    // Monitor for the 2-input instance.
    always @(negedge clk) begin
        int   rel;
        exp_t e;
        if (rst_n) begin
            rel = cyc - e0_2;
            if (rel >= 0 && rel < P2) begin
                chk("busy2", b2.busy, 1);
                chk("drive2", b2.drive, rel / (SET2 + 2));
            end
            if (b2.valid) begin
                nval2++;
                if (q2.size() == 0) begin
                    chk("unexpected_valid2", 1, 0);
                end else begin
                    e = q2.pop_front();
                    chk("table2", b2.table_out, e.tbl);
                    chk("unstable2", b2.unstable, e.unst);
                    chk("done_time2", cyc, e.t_done);
                end
            end
        end
    end

    initial begin
        int nv;
        bit seen;
        b3.start = 1'b0;
        b2.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy3", b3.busy, 0);
        chk("rst_drive3", b3.drive, 0);
        chk("rst_valid3", b3.valid, 0);
        chk("rst_table3", b3.table_out, 0);
        chk("rst_unstable3", b3.unstable, 0);
        chk("rst_table2", b2.table_out, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 0xE3 gate.
        set_e3();
        go3(1, 0);
        wait_idle3();
        chk("e3_table", b3.table_out, 'hE3);
        chk("e3_unstable", b3.unstable, 0);

        // Constant 1, then constant 0 restarted in the valid cycle.
        for (int v = 0; v < 8; v++) lut3[v] = 1'b1;
        go3(1, 0);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (b3.valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("ones_valid_seen", seen, 1);
        chk("ones_table", b3.table_out, 'hFF);
        for (int v = 0; v < 8; v++) lut3[v] = 1'b0;
        b3.start = 1'b1;
        @(posedge clk);
        #1;
        b3.start = 1'b0;
        e0_3 = cyc;
        push3(0);
        wait_idle3();
        chk("zeros_table", b3.table_out, 0);

        // Glitch between the two samples of vector 5.
        set_e3();
        go3(1, 1);
        repeat (34) @(posedge clk);
        #1 glitch3 = 1'b1;
        @(posedge clk);
        #1 glitch3 = 1'b0;
        wait_idle3();
        chk("glitch_bit2", (b3.table_out >> 2) & 1, lut3[5]);

        // Starts while busy are ignored.
        nv = nval3;
        go3(1, 0);
        repeat (8) @(posedge clk);
        go3(0, 0);
        repeat (19) @(posedge clk);
        go3(0, 0);
        wait_idle3();
        repeat (60) @(posedge clk);
        #1;
        chk("valid_once", nval3 - nv, 1);
        chk("idle_after_ignored", b3.busy, 0);

        // Reset mid-sweep after a known table.
        go3(1, 0);
        repeat (20) @(posedge clk);
        #3 rst_n = 1'b0;
        q3.delete();
        e0_3 = -1000;
        #1;
        chk("arst_busy", b3.busy, 0);
        chk("arst_drive", b3.drive, 0);
        chk("arst_valid", b3.valid, 0);
        chk("arst_table", b3.table_out, 0);
        chk("arst_unstable", b3.unstable, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nv = nval3;
        repeat (70) @(posedge clk);
        #1;
        chk("no_valid_after_rst", nval3 - nv, 0);
        chk("busy_after_rst", b3.busy, 0);

        // 2-input AND gate.
        for (int v = 0; v < 4; v++) lut2[v] = (v == 3);
        go2();
        wait_idle2();
        chk("and_table", b2.table_out, 'h1);

        // Random gates on both instances.
        for (int k = 0; k < 6; k++) begin
            for (int v = 0; v < 8; v++)
                lut3[v] = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 4)) @(posedge clk);
            go3(1, 0);
            wait_idle3();
        end
        for (int k = 0; k < 4; k++) begin
            for (int v = 0; v < 4; v++)
                lut2[v] = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 4)) @(posedge clk);
            go2();
            wait_idle2();
        end

        repeat (5) @(posedge clk);
        #1;
        chk("q3_empty", q3.size(), 0);
        chk("q2_empty", q2.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
